// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the machine word plus the instruction cache's
// state encoding, frame layout and default geometry.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS = 16;
  localparam int IIDX_W      = 4;
  localparam int ITAG_W      = 26;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

endpackage

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache with single-word frames, one
// outstanding miss, full invalidate and hit/miss performance counters.
module icache_ctrl
  import cpu_types_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iinv,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  icache_state_t    state_q, state_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [TAG_W-1:0] tag_d  [SETS];
  word_t            data_q [SETS];
  word_t            data_d [SETS];
  word_t            miss_addr_q, miss_addr_d;
  word_t            iaddr_q, iaddr_d;
  logic             iren_q, iren_d;
  logic [31:0]      hit_count_q, hit_count_d;
  logic [31:0]      miss_count_q, miss_count_d;

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             hit, fill;
  logic             unused_addr_bits;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr_q[IDX_W+1:2];
  assign fill_tag = miss_addr_q[31:IDX_W+2];
  assign unused_addr_bits = ^{imemaddr[1:0], miss_addr_q[1:0]};

  // Hits are only served while no fill is pending, with zero latency.
  assign hit  = (state_q == IDLE) && imemREN && valid_q[req_idx]
                && (tag_q[req_idx] == req_tag);
  assign fill = (state_q == FETCH) && !iwait;

  assign ihit       = hit;
  assign imemload   = hit ? data_q[req_idx] : '0;
  assign iREN       = iren_q;
  assign iaddr      = iaddr_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    miss_addr_d  = miss_addr_q;
    iaddr_d      = iaddr_q;
    iren_d       = iren_q;
    miss_count_d = miss_count_q;
    hit_count_d  = hit_count_q + 32'(hit);
    case (state_q)
      IDLE: begin
        if (imemREN && !hit) begin
          state_d      = FETCH;
          miss_addr_d  = {imemaddr[31:2], 2'b00};
          iaddr_d      = {imemaddr[31:2], 2'b00};
          iren_d       = 1'b1;
          miss_count_d = miss_count_q + 32'd1;
        end
      end
      FETCH: begin
        if (fill) begin
          state_d           = IDLE;
          iaddr_d           = '0;
          iren_d            = 1'b0;
          valid_d[fill_idx] = 1'b1;
          tag_d[fill_idx]   = fill_tag;
          data_d[fill_idx]  = iload;
        end
      end
      default: state_d = IDLE;
    endcase
    // Invalidate overrides a fill landing in the same cycle.
    if (iinv) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_addr_q  <= '0;
      iaddr_q      <= '0;
      iren_q       <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      miss_addr_q  <= miss_addr_d;
      iaddr_q      <= iaddr_d;
      iren_q       <= iren_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data need no reset; the valid bits guard them.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural cache model.
module tb_icache_ctrl;

  logic        CLK = 1'b0;
  logic        RST, imemREN, iinv, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, hit_count, miss_count;

  always #5 CLK = ~CLK;

  icache_ctrl dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iinv(iinv), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: per set, which word address it holds (if any) and that word.
  bit          m_known = 1'b0;
  bit          m_valid [16];
  logic [29:0] m_line  [16];
  logic [31:0] m_data  [16];
  bit          m_busy;
  logic [31:0] m_miss_addr;
  logic [31:0] m_hits, m_misses;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ren,
                               input logic [31:0] addr, input logic inv,
                               input logic wt, input logic [31:0] ld);
    RST = rst; imemREN = ren; imemaddr = addr; iinv = inv; iwait = wt; iload = ld;
    #2;
  endtask

  // Compare every output with the model mid-cycle, then advance the model.
  task automatic endCycle();
    logic [29:0] word;
    int          set, fset;
    bit          exp_hit;
    logic [31:0] exp_load;
    @(negedge CLK);
    word     = imemaddr[31:2];
    set      = int'(word % 30'd16);
    exp_hit  = !m_busy && imemREN && m_valid[set] && (m_line[set] == word);
    exp_load = exp_hit ? m_data[set] : 32'h0;
    if (m_known) begin
      checkOutput("model_ihit", {31'b0, ihit}, {31'b0, exp_hit});
      checkOutput("model_imemload", imemload, exp_load);
      checkOutput("model_iREN", {31'b0, iREN}, {31'b0, m_busy});
      checkOutput("model_iaddr", iaddr, m_busy ? m_miss_addr : 32'h0);
      checkOutput("model_hit_count", hit_count, m_hits);
      checkOutput("model_miss_count", miss_count, m_misses);
    end
    if (RST) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_busy = 1'b0; m_miss_addr = '0; m_hits = '0; m_misses = '0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (exp_hit) m_hits++;
      if (!m_busy) begin
        if (imemREN && !exp_hit) begin
          m_busy = 1'b1;
          m_miss_addr = {word, 2'b00};
          m_misses++;
        end
      end else if (!iwait) begin
        fset = int'((m_miss_addr / 4) % 16);
        m_valid[fset] = 1'b1;
        m_line[fset]  = m_miss_addr[31:2];
        m_data[fset]  = iload;
        m_busy = 1'b0;
      end
      if (iinv) foreach (m_valid[i]) m_valid[i] = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [25:0] tags [3];
    logic [25:0] rtag;
    logic [3:0]  ridx;
    logic [1:0]  rlow;
    tags[0] = 26'h0; tags[1] = 26'h1; tags[2] = 26'h3ABCDEF;

    applyStimulus(1, 0, 0, 0, 1, 0); endCycle();
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkOutput("reset_iREN", {31'b0, iREN}, 0);
    checkOutput("reset_iaddr", iaddr, 0);
    checkOutput("reset_ihit", {31'b0, ihit}, 0);
    checkOutput("reset_imemload", imemload, 0);
    checkOutput("reset_hit_count", hit_count, 0);
    checkOutput("reset_miss_count", miss_count, 0);
    endCycle();

    // Cold miss at 0x0
    applyStimulus(0, 1, 32'h0, 0, 1, 0);
    checkOutput("cold_ihit", {31'b0, ihit}, 0); endCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h0, 0, 1, 0);
      checkOutput("cold_iREN", {31'b0, iREN}, 1);
      checkOutput("cold_iaddr", iaddr, 32'h0);
      endCycle();
    end
    applyStimulus(0, 1, 32'h0, 0, 0, 32'h8C010004); endCycle();
    applyStimulus(0, 1, 32'h0, 0, 1, 0);
    checkOutput("retry_ihit", {31'b0, ihit}, 1);
    checkOutput("retry_imemload", imemload, 32'h8C010004);
    checkOutput("retry_miss_count", miss_count, 1);
    endCycle();

    // Repeat hits with ignored byte offset
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 32'h2, 0, 1, 0);
      checkOutput("repeat_ihit", {31'b0, ihit}, 1);
      checkOutput("repeat_iREN", {31'b0, iREN}, 0);
      checkOutput("repeat_imemload", imemload, 32'h8C010004);
      endCycle();
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("repeat_hit_count", hit_count, 3); endCycle();

    // Conflict on set 0
    applyStimulus(0, 1, 32'h40, 0, 1, 0);
    checkOutput("conflict_ihit", {31'b0, ihit}, 0); endCycle();
    applyStimulus(0, 1, 32'h40, 0, 0, 32'h12345678);
    checkOutput("conflict_iaddr", iaddr, 32'h40); endCycle();
    applyStimulus(0, 1, 32'h0, 0, 1, 0);
    checkOutput("conflict_back_ihit", {31'b0, ihit}, 0); endCycle();
    applyStimulus(0, 1, 32'h0, 0, 0, 32'h8C010004);
    checkOutput("conflict_back_iaddr", iaddr, 32'h0); endCycle();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("conflict_miss_count", miss_count, 3); endCycle();

    // Address change mid-fetch
    applyStimulus(0, 1, 32'h4, 0, 1, 0); endCycle();
    applyStimulus(0, 1, 32'h8, 0, 1, 0);
    checkOutput("midfetch_iaddr", iaddr, 32'h4); endCycle();
    applyStimulus(0, 0, 32'h8, 0, 0, 32'hAAAA0004);
    checkOutput("midfetch_fill_iaddr", iaddr, 32'h4); endCycle();
    applyStimulus(0, 1, 32'h4, 0, 1, 0);
    checkOutput("midfetch_frame1", imemload, 32'hAAAA0004); endCycle();
    applyStimulus(0, 1, 32'h8, 0, 1, 0);
    checkOutput("midfetch_8_ihit", {31'b0, ihit}, 0); endCycle();
    applyStimulus(0, 1, 32'h8, 0, 0, 32'hBBBB0008);
    checkOutput("midfetch_8_iaddr", iaddr, 32'h8); endCycle();

    // Invalidate in IDLE
    applyStimulus(0, 0, 0, 1, 1, 0); endCycle();
    applyStimulus(0, 1, 32'h0, 0, 1, 0);
    checkOutput("inv_0_ihit", {31'b0, ihit}, 0); endCycle();
    applyStimulus(0, 1, 32'h0, 0, 0, 32'h8C010004); endCycle();
    applyStimulus(0, 1, 32'h4, 0, 1, 0);
    checkOutput("inv_4_ihit", {31'b0, ihit}, 0); endCycle();
    applyStimulus(0, 1, 32'h4, 0, 0, 32'hAAAA0004); endCycle();

    // Invalidate coinciding with a fill
    applyStimulus(0, 1, 32'h8, 0, 1, 0); endCycle();
    applyStimulus(0, 1, 32'h8, 1, 0, 32'hBBBB0008); endCycle();
    applyStimulus(0, 1, 32'h8, 0, 1, 0);
    checkOutput("invfill_ihit", {31'b0, ihit}, 0); endCycle();
    applyStimulus(0, 1, 32'h8, 0, 0, 32'hBBBB0008); endCycle();
    applyStimulus(0, 1, 32'h8, 0, 1, 0);
    checkOutput("refill_imemload", imemload, 32'hBBBB0008); endCycle();

    // Hit and invalidate in the same cycle
    applyStimulus(0, 1, 32'h8, 1, 1, 0);
    checkOutput("hitinv_ihit", {31'b0, ihit}, 1); endCycle();
    applyStimulus(0, 1, 32'h8, 0, 1, 0);
    checkOutput("hitinv_after_ihit", {31'b0, ihit}, 0); endCycle();

    // Reset while a fetch is outstanding
    applyStimulus(1, 1, 32'h8, 0, 1, 0);
    checkOutput("rstfetch_iREN_before", {31'b0, iREN}, 1); endCycle();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("rstfetch_iREN", {31'b0, iREN}, 0);
    checkOutput("rstfetch_iaddr", iaddr, 0);
    checkOutput("rstfetch_hit_count", hit_count, 0);
    checkOutput("rstfetch_miss_count", miss_count, 0);
    endCycle();
    applyStimulus(0, 1, 32'h0, 0, 1, 0);
    checkOutput("rstfetch_0_ihit", {31'b0, ihit}, 0); endCycle();
    applyStimulus(0, 1, 32'h0, 0, 0, 32'h11110000); endCycle();
    applyStimulus(0, 1, 32'h4, 0, 1, 0);
    checkOutput("rstfetch_4_ihit", {31'b0, ihit}, 0); endCycle();
    applyStimulus(0, 0, 0, 0, 0, 32'h22220004); endCycle();

    // Randomized traffic over a few aliasing tags
    for (int n = 0; n < 3000; n++) begin
      rtag = tags[$urandom_range(2, 0)];
      ridx = 4'($urandom_range(15, 0));
      rlow = 2'($urandom_range(3, 0));
      applyStimulus(($urandom_range(255, 0) == 0), ($urandom_range(3, 0) != 0),
                    {rtag, ridx, rlow}, ($urandom_range(39, 0) == 0),
                    1'($urandom_range(1, 0)), $urandom);
      endCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
